// File: rtl/tdc_wsign.sv
// tdc_wsign: measures a synchronous pulse width in clk cycles and reports a saturated signed code.
// Optional abort on long pulses when TDC_TIMEOUT_EN is defined.
module tdc_wsign #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = WIDTH + 1,
    parameter int TIMEOUT = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             sign_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    localparam logic [CNT_W-1:0] MAXP = CNT_W'(2 ** (WIDTH - 1) - 1);
    localparam logic [CNT_W-1:0] MAXN = CNT_W'(2 ** (WIDTH - 1));
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
`ifdef TDC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, mag, neg;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic sign_q, sign_d, ovf_q, ovf_d, pulse_q, rise, to_hit;

    always_comb begin
        rise    = pulse_in & ~pulse_q;
        to_hit  = TO_EN && pulse_in && (cnt_q >= TMO);
        mag     = sign_q ? ((cnt_q > MAXN) ? MAXN : cnt_q) : ((cnt_q > MAXP) ? MAXP : cnt_q);
        neg     = CNT_W'(0) - mag;
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        if (state_q == MEASURE) begin
            if (to_hit) begin
                state_d = REPORT;
                dout_d  = sign_q ? WIDTH'(CNT_W'(0) - MAXN) : WIDTH'(MAXP);
                ovf_d   = 1'b1;
            end else if (pulse_in) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end else begin
                state_d = REPORT;
                dout_d  = sign_q ? neg[WIDTH-1:0] : mag[WIDTH-1:0];
                ovf_d   = sign_q ? (cnt_q > MAXN) : (cnt_q > MAXP);
            end
        end else if (rise) begin
            // Accepted from IDLE and from REPORT, so back-to-back pulses are measured.
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            sign_d  = sign_in;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            pulse_q <= pulse_in;
        end
    end

    assign dout       = dout_q;
    assign overflow   = ovf_q;
    assign dout_valid = (state_q == REPORT);
    assign busy       = (state_q == MEASURE);
endmodule

// File: tb/tb_tdc_wsign.sv
// tb_tdc_wsign: directed checks of tdc_wsign with hand-computed codes.
module tb_tdc_wsign;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse_in = 1'b0;
    logic sign_in = 1'b0;
    logic [7:0] dout;
    logic dout_valid, overflow, busy;

    int total = 0;
    int bad = 0;
    int strobes, busy_cnt;
    logic [7:0] first_dout, last_dout;
    logic last_ovf;

    tdc_wsign #(.WIDTH(8), .CNT_W(9), .TIMEOUT(300)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .sign_in(sign_in),
        .dout(dout), .dout_valid(dout_valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic s);
        pulse_in = p;
        sign_in  = s;
        @(posedge clk);
        #1;
        if (dout_valid) begin
            if (strobes == 0) first_dout = dout;
            last_dout = dout;
            last_ovf  = overflow;
            strobes++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic clr();
        strobes  = 0;
        busy_cnt = 0;
    endtask

    task automatic pulse(input int n, input logic s, input logic tog);
        clr();
        for (int i = 0; i < n; i++) step(1'b1, (tog && i >= n / 2) ? ~s : s);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        clr();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        pulse(50, 1'b0, 1'b0);
        chk("pos50_strobes", 32'(strobes), 32'd1);
        chk("pos50_dout", 32'(last_dout), 32'd50);
        chk("pos50_ovf", 32'(last_ovf), 32'd0);
        chk("pos50_busy", 32'(busy_cnt), 32'd50);

        pulse(50, 1'b1, 1'b1);
        chk("neg50_strobes", 32'(strobes), 32'd1);
        chk("neg50_dout", 32'(last_dout), 32'hCE);
        chk("neg50_ovf", 32'(last_ovf), 32'd0);

        pulse(127, 1'b0, 1'b0);
        chk("p127_dout", 32'(last_dout), 32'h7F);
        chk("p127_ovf", 32'(last_ovf), 32'd0);
        pulse(128, 1'b1, 1'b0);
        chk("n128_dout", 32'(last_dout), 32'h80);
        chk("n128_ovf", 32'(last_ovf), 32'd0);
        pulse(128, 1'b0, 1'b0);
        chk("p128_dout", 32'(last_dout), 32'h7F);
        chk("p128_ovf", 32'(last_ovf), 32'd1);
        pulse(200, 1'b1, 1'b0);
        chk("n200_dout", 32'(last_dout), 32'h80);
        chk("n200_ovf", 32'(last_ovf), 32'd1);
`ifndef TDC_TIMEOUT_EN
        pulse(520, 1'b0, 1'b0);
        chk("sat_strobes", 32'(strobes), 32'd1);
        chk("sat_dout", 32'(last_dout), 32'h7F);
        chk("sat_ovf", 32'(last_ovf), 32'd1);
`endif

        clr();
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 49; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("mid_rst_strobes", 32'(strobes), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        pulse(10, 1'b0, 1'b0);
        chk("after_rst_strobes", 32'(strobes), 32'd1);
        chk("after_rst_dout", 32'(last_dout), 32'd10);

        clr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("b2b_strobes", 32'(strobes), 32'd2);
        chk("b2b_first", 32'(first_dout), 32'd5);
        chk("b2b_second", 32'(last_dout), 32'd7);

        clr();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("zero_strobes", 32'(strobes), 32'd0);
        chk("zero_dout", 32'(dout), 32'd7);

        rst = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
        clr();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("held_strobes", 32'(strobes), 32'd0);
        chk("held_busy", 32'(busy_cnt), 32'd0);

`ifdef TDC_TIMEOUT_EN
        pulse(400, 1'b0, 1'b0);
        chk("to_strobes", 32'(strobes), 32'd1);
        chk("to_dout", 32'(last_dout), 32'h7F);
        chk("to_ovf", 32'(last_ovf), 32'd1);
        chk("to_busy", 32'(busy_cnt), 32'd300);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
